unidade_mult_div: RTL
=====================

# unidade_mult_div

Iterative multiply/divide unit for the MIPS datapath. It sits directly downstream of the register file and takes the two read ports (rs, rt) as operands. It executes MULT, MULTU, DIV and DIVU over a fixed number of cycles and holds the results in internal HI/LO registers. It also supports MTHI/MTLO writes. HI/LO are read combinationally and fed back through the writeback mux into the register file's data input for MFHI/MFLO.

## Interface
Parameters:
- none; width fixed at 32 bits, iteration count fixed at 32.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  launch operation; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- operando_a  in  32  rs value (multiplicand / dividend).
- operando_b  in  32  rt value (multiplier / divisor).
- wr_hi  in  1  MTHI: write data_in to HI.
- wr_lo  in  1  MTLO: write data_in to LO.
- data_in  in  32  value for MTHI/MTLO.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when HI/LO are updated by an operation.
- div_zero  out  1  one-cycle pulse, coincident with done, when a DIV/DIVU had divisor 0.
- hi_out  out  32  current HI register.
- lo_out  out  32  current LO register.

## Operation
- States:
  - IDLE: busy=0.
  - CALC: 32 iterations, busy=1.
  - FIX: sign correction and HI/LO write, busy=1.
- Transitions:
  - IDLE→CALC on start.
  - CALC→FIX after the 32nd iteration; the counter is 5 bits and wraps 31→0.
  - FIX→IDLE unconditionally.
- Operand capture in IDLE on start:
  - Signed ops register magnitudes |a|, |b| as unsigned 32-bit values; |0x80000000| = 0x80000000.
  - The unit also registers neg_q = a[31]^b[31] and neg_r = a[31].
  - Unsigned ops take the raw values with both neg flags 0.
- Multiply: radix-2 shift-add over a 64-bit product, one multiplier bit per CALC cycle, LSB first.
  - FIX: if neg_q, the product is two's-complement negated.
  - Result: HI=product[63:32], LO=product[31:0].
- Divide: restoring division, one quotient bit per CALC cycle, MSB first; the remainder is 33 bits internally.
  - FIX: the quotient is negated if neg_q; the remainder is negated if neg_r.
  - Result: LO=quotient, HI=remainder.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. No trap.
- Divisor zero: the unit still runs the full latency. FIX forces LO=0xFFFFFFFF and HI=operando_a as captured (the original signed value, not its magnitude), and pulses div_zero.
- MTHI/MTLO:
  - Honoured only in IDLE with start=0, written at the clock edge; wr_hi and wr_lo together write both.
  - Ignored while busy.
  - Ignored in the same cycle start is accepted (start has priority).
- start while busy is ignored; no queuing.
- operando_a, operando_b and op need only be valid in the start cycle.

## Timing
- Reset (asynchronous, immediate, including mid-operation):
  - State=IDLE, counter=0.
  - HI=LO=0.
  - busy=0, done=0, div_zero=0.
  - Any in-flight result is discarded.
- Start accepted at edge E0:
  - busy=1 after E0.
  - CALC occupies edges E1..E32.
  - FIX at E33 writes HI/LO.
  - After E33: busy=0, done=1 for exactly one cycle, and hi_out/lo_out show the new result. Latency is 33 cycles for every op, including divide-by-zero.
- A new start is legal in the cycle done=1; the unit is IDLE then. Back-to-back operations are therefore spaced 34 cycles apart.
- hi_out/lo_out change only at E33 of an operation, on an MTHI/MTLO edge, or on reset; they are stable throughout CALC.
- done and div_zero are registered outputs, with no combinational path from start.

## Test plan
- Reset, then MULT a=7, b=0xFFFFFFFD (−3) → done after 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high for exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. MULT a=b=0x80000000 → HI=0x40000000, LO=0.
- DIV a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=7 → LO=14, HI=2.
- DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0. DIVU a=5, b=0 → LO=0xFFFFFFFF, HI=5, with div_zero and done pulsed together.
- MTHI 0x12345678 while idle → hi_out=0x12345678 next cycle. MTLO pulsed during CALC → LO unchanged until E33. Second start during busy → ignored, single done pulse.
- Start MULTU 3×4, drop reset_n at cycle 10 → busy, done, HI and LO immediately 0. After release, a new MULTU 3×4 yields LO=12, HI=0 at 33 cycles.

Source files
------------

// File: rtl/unidade_mult_div_if.sv
// Operand/result bundle between the register file, writeback mux and the
// iterative multiply/divide unit.
interface unidade_mult_div_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operando_a;
  logic [31:0] operando_b;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] data_in;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport master (
    output start, op, operando_a, operando_b, wr_hi, wr_lo, data_in,
    input  busy, done, div_zero, hi_out, lo_out
  );

  modport slave (
    input  start, op, operando_a, operando_b, wr_hi, wr_lo, data_in,
    output busy, done, div_zero, hi_out, lo_out
  );
endinterface

// File: rtl/unidade_mult_div.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers: 32 shift-add or
// restoring-divide steps on magnitudes, then one sign-fix/writeback cycle.
module unidade_mult_div (
  input  logic                clock,
  input  logic                reset_n,
  unidade_mult_div_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // Multiply: {partial product, remaining multiplier}. Divide: [31:0] dividend -> quotient.
  logic [63:0] acc_q, acc_d;
  logic [32:0] rem_q, rem_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] a_raw_q, a_raw_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        is_div_q, is_div_d;
  logic        negq_q, negq_d, negr_q, negr_d;
  logic        done_q, done_d, dz_q, dz_d;

  logic        signed_op;
  logic [31:0] a_mag, b_mag;
  logic [32:0] add_sum;
  logic [32:0] trial;
  logic [33:0] diff;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opnd_d   = opnd_q;
    a_raw_d  = a_raw_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;

    signed_op = ~bus.op[0];
    a_mag     = (signed_op && bus.operando_a[31]) ? -bus.operando_a : bus.operando_a;
    b_mag     = (signed_op && bus.operando_b[31]) ? -bus.operando_b : bus.operando_b;
    add_sum   = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
    trial     = {rem_q[31:0], acc_q[31]};
    diff      = {1'b0, trial} - {2'b00, opnd_q};
    prod_fix  = negq_q ? -acc_q : acc_q;
    quot_fix  = negq_q ? -acc_q[31:0] : acc_q[31:0];
    rem_fix   = negr_q ? -rem_q[31:0] : rem_q[31:0];

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d  = StCalc;
          cnt_d    = 5'd0;
          is_div_d = bus.op[1];
          negq_d   = signed_op & (bus.operando_a[31] ^ bus.operando_b[31]);
          negr_d   = signed_op & bus.operando_a[31];
          a_raw_d  = bus.operando_a;
          rem_d    = 33'd0;
          if (bus.op[1]) begin
            acc_d  = {32'd0, a_mag};
            opnd_d = b_mag;
          end else begin
            acc_d  = {32'd0, b_mag};
            opnd_d = a_mag;
          end
        end else begin
          if (bus.wr_hi) hi_d = bus.data_in;
          if (bus.wr_lo) lo_d = bus.data_in;
        end
      end
      StCalc: begin
        cnt_d = cnt_q + 5'd1;
        if (is_div_q) begin
          if (!diff[33]) begin
            rem_d = diff[32:0];
            acc_d = {acc_q[63:32], acc_q[30:0], 1'b1};
          end else begin
            rem_d = trial;
            acc_d = {acc_q[63:32], acc_q[30:0], 1'b0};
          end
        end else if (acc_q[0]) begin
          acc_d = {add_sum, acc_q[31:1]};
        end else begin
          acc_d = {1'b0, acc_q[63:1]};
        end
        if (cnt_q == 5'd31) state_d = StFix;
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else if (opnd_q == 32'd0) begin
          // Divide by zero reports the dividend as originally presented.
          hi_d = a_raw_q;
          lo_d = 32'hFFFF_FFFF;
          dz_d = 1'b1;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      rem_q    <= 33'd0;
      opnd_q   <= 32'd0;
      a_raw_q  <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      is_div_q <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opnd_q   <= opnd_d;
      a_raw_q  <= a_raw_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi_out   = hi_q;
  assign bus.lo_out   = lo_q;

endmodule
